// File: rtl/wfg_dds_gen.sv
// DDS waveform generator: phase accumulator, live phase offset, eight waveform
// shapes (incl. per-period LFSR noise), amplitude scaling and a period-sync pulse.
module wfg_dds_gen #(
   parameter int              ACC_W     = 16,
   parameter int              OUT_W     = 8,
   parameter int              OFF_W     = 8,
   parameter logic [OUT_W-1:0] LFSR_SEED = 'h1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ld,
   input  logic             clr,
   input  logic [ACC_W-1:0] tw,
   input  logic [OFF_W-1:0] phase_off,
   input  logic [2:0]       func,
   input  logic [OUT_W:0]   amp,
   output logic [OUT_W-1:0] out,
   output logic             wrap
);

   localparam int N = 1 << OUT_W;
   localparam int MID_I = 1 << (OUT_W - 1);
   localparam logic [OUT_W-1:0] MAX = {OUT_W{1'b1}};
   localparam logic [OUT_W-1:0] MID = OUT_W'(MID_I);
   localparam logic [OUT_W:0] UNITY = (OUT_W + 1)'(N);

   function automatic logic [31:0] lfsr_taps(input int w);
      case (w)
         2:       return 32'h3;
         3:       return 32'h6;
         4:       return 32'hC;
         5:       return 32'h14;
         6:       return 32'h30;
         7:       return 32'h60;
         8:       return 32'hB8;
         9:       return 32'h110;
         10:      return 32'h240;
         11:      return 32'h500;
         12:      return 32'h829;
         13:      return 32'h100D;
         14:      return 32'h2015;
         15:      return 32'h6000;
         17:      return 32'h12000;
         18:      return 32'h20400;
         24:      return 32'hE10000;
         32:      return 32'h80200003;
         default: return 32'hD008;
      endcase
   endfunction

   localparam logic [OUT_W-1:0] TAPS = OUT_W'(lfsr_taps(OUT_W));

   // Elaboration-time sine via range-reduced Taylor series, rounded half away from zero
   function automatic logic [OUT_W-1:0] sine_at(input int i);
      real x, term, s, v;
      int  r;
      x = 2.0 * 3.141592653589793 * real'(i) / real'(N);
      if (x > 3.141592653589793) x = x - 2.0 * 3.141592653589793;
      s    = x;
      term = x;
      for (int k = 1; k < 14; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         s    = s + term;
      end
      v = real'(MID_I - 1) * s;
      r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      return OUT_W'(MID_I + r);
   endfunction

   logic [OUT_W-1:0] rom [N];
   for (genvar gi = 0; gi < N; gi++) begin : g_rom
      assign rom[gi] = sine_at(gi);
   end

   logic [ACC_W-1:0] acc_q, tw_q;
   logic [OFF_W-1:0] off_q;
   logic [2:0]       func_q;
   logic [OUT_W:0]   amp_q, amp_d;
   logic [OUT_W-1:0] lfsr_q;
   logic             wrap_p0_q, wrap_p1_q, wrap_p2_q, wrap_q;
   logic [OUT_W-1:0] ph_p1_q, ph_d, w_p2_q, w_d, out_q, out_d;
   logic [ACC_W:0]   sum_d;
   logic [ACC_W-1:0] phase_d;
   logic [OUT_W-1:0] tri_v, sine_s, dev_v, rect_v;
   logic [OUT_W:0]   dev2_v;
   logic [2*OUT_W:0] prod_d;

   assign amp_d   = (amp > UNITY) ? UNITY : amp;
   assign sum_d   = {1'b0, acc_q} + {1'b0, tw_q};
   assign phase_d = acc_q + (ACC_W'(off_q) << (ACC_W - OFF_W));
   assign ph_d    = OUT_W'(phase_d >> (ACC_W - OUT_W));

   assign tri_v  = {ph_p1_q[OUT_W-2:0], 1'b0};
   assign sine_s = rom[ph_p1_q];
   assign dev_v  = (sine_s >= MID) ? (sine_s - MID) : (MID - sine_s);
   assign dev2_v = {dev_v, 1'b0};
   assign rect_v = (dev2_v > {1'b0, MAX}) ? MAX : OUT_W'(dev2_v);

   always_comb begin
      w_d = '0;
      case (func_q)
         3'd0:    w_d = ph_p1_q[OUT_W-1] ? MAX : '0;
         3'd1:    w_d = ph_p1_q;
         3'd2:    w_d = MAX - ph_p1_q;
         3'd3:    w_d = ph_p1_q[OUT_W-1] ? (MAX - tri_v) : tri_v;
         3'd4:    w_d = sine_s;
         3'd5:    w_d = rect_v;
         3'd6:    w_d = (sine_s >= MID) ? rect_v : '0;
         default: w_d = lfsr_q;
      endcase
   end

   assign prod_d = (2*OUT_W+1)'(w_p2_q) * (2*OUT_W+1)'(amp_q);
   assign out_d  = OUT_W'(prod_d >> OUT_W);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         tw_q      <= '0;
         off_q     <= '0;
         func_q    <= '0;
         amp_q     <= UNITY;
         lfsr_q    <= LFSR_SEED;
         wrap_p0_q <= 1'b0;
         ph_p1_q   <= '0;
         wrap_p1_q <= 1'b0;
         w_p2_q    <= '0;
         wrap_p2_q <= 1'b0;
         out_q     <= '0;
         wrap_q    <= 1'b0;
      end else begin
         if (ld) begin
            tw_q   <= tw;
            off_q  <= phase_off;
            func_q <= func;
            amp_q  <= amp_d;
         end
         // stage 0: accumulator
         if (clr) begin
            acc_q     <= '0;
            wrap_p0_q <= 1'b0;
         end else if (en) begin
            acc_q     <= sum_d[ACC_W-1:0];
            wrap_p0_q <= sum_d[ACC_W];
         end else begin
            wrap_p0_q <= 1'b0;
         end
         if (wrap_p0_q) lfsr_q <= {lfsr_q[OUT_W-2:0], ^(lfsr_q & TAPS)};
         // stage 1: offset phase
         ph_p1_q   <= ph_d;
         wrap_p1_q <= wrap_p0_q;
         // stage 2: waveform
         w_p2_q    <= w_d;
         wrap_p2_q <= wrap_p1_q;
         // stage 3: amplitude
         out_q     <= out_d;
         wrap_q    <= wrap_p2_q;
      end
   end

   assign out  = out_q;
   assign wrap = wrap_q;

endmodule

// File: doc/wfg_dds_gen.md
Name: wfg_dds_gen

Overview:
- Parametrised single-clock successor to the team's DDS waveform generator.
- Contains a wide phase accumulator, a load-buffered tuning/offset/function/amplitude register set, eight waveform modes including LFSR noise, amplitude scaling and a wrap (period-sync) pulse.
- Sits between the control register block and the DAC driver; one instance per output channel.

Parameters:
- ACC_W, 16, phase accumulator width (>= OUT_W+2).
- OUT_W, 8, output sample width, unsigned offset-binary.
- OFF_W, 8, phase-offset input width (<= ACC_W).
- LFSR_SEED, 'h1, nonzero reset seed of the OUT_W-bit noise LFSR.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  accumulator advance enable.
- ld  in  1  load strobe; captures tw, phase_off, func, amp.
- clr  in  1  phase clear; accumulator to 0 on the next edge.
- tw  in  ACC_W  tuning word (phase increment).
- phase_off  in  OFF_W  phase offset, MSB-aligned onto the accumulator.
- func  in  3  waveform select.
- amp  in  OUT_W+1  amplitude; 2^OUT_W = unity, larger values clamp to unity.
- out  out  OUT_W  sample.
- wrap  out  1  one-cycle pulse on accumulator carry-out.

Behaviour:
- Reset (rst=1 at an edge) wins over every other input:
  - acc, tw_r, off_r, func_r <= 0; amp_r <= 2^OUT_W; lfsr <= LFSR_SEED.
  - All pipeline registers, out and wrap <= 0.
- Reset mid-operation discards all in-flight samples; out is 0 on the edge after rst rises.
- Load: ld=1 captures tw_r, off_r, func_r, amp_r (amp clamped) at that edge. New values take effect on the following edges; acc is not disturbed.
- Accumulator, stage 0, priority rst > clr > en:
  - clr: acc <= 0, wrap_p <= 0.
  - en: {carry, acc} <= acc + tw_r, modulo 2^ACC_W; wrap_p <= carry.
  - Neither: hold acc, wrap_p <= 0.
- clr and ld on the same edge are both honoured.
- Stage 1: ph <= top OUT_W bits of (acc + (off_r << (ACC_W-OFF_W))) mod 2^ACC_W. The offset is a live term and never modifies acc.
- Stage 2, waveform w from ph; MAX = 2^OUT_W-1, MID = 2^(OUT_W-1):
  - 0 square: ph MSB=0 -> 0, else MAX.
  - 1 rising saw: ph.
  - 2 falling saw: MAX-ph.
  - 3 triangle: d = (ph<<1) mod 2^OUT_W; MSB=0 -> d, else MAX-d.
  - 4 sine: ROM[ph], 2^OUT_W entries built at elaboration, ROM[i] = MID + round((MID-1)*sin(2*pi*i/2^OUT_W)).
  - 5 full-wave rectified: s = ROM[ph]; min(MAX, 2*|s-MID|).
  - 6 half-wave rectified: s >= MID -> min(MAX, 2*(s-MID)), else 0.
  - 7 noise: lfsr value. LFSR is a maximal-length Fibonacci over OUT_W bits; it advances only in cycles where wrap_p=1, i.e. one new value per period.
- Stage 3: out <= (w * amp_r) >> OUT_W, truncating. amp_r = 2^OUT_W gives out = w exactly.
- wrap is wrap_p delayed to stay aligned with out.
- Latency: an acc value appears on out 3 edges after it is registered. A func/amp change through ld reaches out within 3 edges.
- tw_r = 0 freezes phase; out is then constant for the held ph.

Test Plan:
- Reset: rst=1 for 2 cycles with ld/en active -> out=0, wrap=0. After release, func 0 with tw=0 gives out=0 indefinitely.
- Saw (tw=256, func=1, amp=256, en=1) -> out steps 0,1,2,...,255,0 one per cycle. wrap pulses exactly once every 256 cycles, coincident with out=0.
- Square, triangle, falling saw, each with tw=256:
  - square: 128 cycles at 0, then 128 at 255;
  - triangle: 0,2,...,254,255,253,...,1;
  - falling saw: 255 down to 0.
- Sine: tw=0, ld with phase_off = 0, 64, 128, 192 in turn -> out = 128, 255, 128, 1 after 3 cycles. With func=5 and phase_off=192 -> 254. With func=6 and the same offset -> 0.
- Amplitude/load: saw running, ld amp=128 -> out = floor(ph/2), e.g. ph=200 gives 100 three edges later. ld amp=511 -> clamps to unity.
- clr and reset mid-run: with tw=1000, clr pulse -> acc=0; out = ph 0 value after 3 edges. rst during run -> out=0 next edge, LFSR restarts at LFSR_SEED, and the noise sequence repeats identically.
